// File: rtl/mygo_chan_send_arb.sv
// mygo_chan_send_arb: round-robin arbiter sharing one FIFO write port among NUM_SENDERS producers.
// Define MYGO_CHAN_ARB_STATS_EN to add xfer_count/stall_count outputs.
module mygo_chan_send_arb #(
    parameter int NUM_SENDERS = 4,
    parameter int WIDTH = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SENDERS-1:0]       s_valid,
    input  logic [NUM_SENDERS*WIDTH-1:0] s_data,
    output logic [NUM_SENDERS-1:0]       s_ready,
    output logic [WIDTH-1:0]             fifo_in_data,
    output logic                         fifo_in_valid,
    input  logic                         fifo_in_ready,
    output logic [NUM_SENDERS-1:0]       grant,
    output logic                         busy
`ifdef MYGO_CHAN_ARB_STATS_EN
    ,
    output logic [31:0]                  xfer_count,
    output logic [31:0]                  stall_count
`endif
);
    localparam int PW = $clog2(NUM_SENDERS);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_q, state_d;
    logic [NUM_SENDERS-1:0] grant_q, grant_d;
    logic [PW-1:0]          gidx_q, gidx_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]          win;
    logic [WIDTH-1:0]       s_arr [NUM_SENDERS];
    logic                   in_grant, g_valid, hs, rel;

    for (genvar i = 0; i < NUM_SENDERS; i++) begin : g_unpack
        assign s_arr[i] = s_data[i*WIDTH +: WIDTH];
    end

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        win = '0;
        for (int k = NUM_SENDERS - 1; k >= 0; k--)
            win = s_valid[(int'(rr_ptr_q) + k) % NUM_SENDERS] ? PW'((int'(rr_ptr_q) + k) % NUM_SENDERS) : win;
    end

    assign in_grant      = (state_q == GRANT);
    assign g_valid       = s_valid[gidx_q];
    assign hs            = in_grant & g_valid & fifo_in_ready;
    assign rel           = ~g_valid | (fifo_in_ready & (beat_cnt_q == BW'(MAX_BURST - 1)));
    assign fifo_in_valid = in_grant & g_valid;
    assign fifo_in_data  = in_grant ? s_arr[gidx_q] : '0;
    assign s_ready       = (in_grant & fifo_in_ready) ? grant_q : '0;
    assign grant         = grant_q;
    assign busy          = in_grant;

    always_comb begin
        state_d    = !in_grant ? (|s_valid ? GRANT : IDLE) : (rel ? IDLE : GRANT);
        grant_d    = !in_grant ? (|s_valid ? NUM_SENDERS'(1) << win : '0) : (rel ? '0 : grant_q);
        gidx_d     = (!in_grant && |s_valid) ? win : gidx_q;
        beat_cnt_d = (!in_grant || rel) ? '0 : (hs ? beat_cnt_q + BW'(1) : beat_cnt_q);
        rr_ptr_d   = (in_grant && rel) ? ((gidx_q == PW'(NUM_SENDERS - 1)) ? '0 : gidx_q + PW'(1)) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef MYGO_CHAN_ARB_STATS_EN
    logic [31:0] xfer_q, xfer_d, stall_q, stall_d;

    always_comb begin
        xfer_d  = hs ? xfer_q + 32'd1 : xfer_q;
        stall_d = (fifo_in_valid & ~fifo_in_ready) ? stall_q + 32'd1 : stall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            xfer_q  <= xfer_d;
            stall_q <= stall_d;
        end
    end

    assign xfer_count  = xfer_q;
    assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_mygo_chan_send_arb.sv
// tb_mygo_chan_send_arb: randomized scoreboard bench for mygo_chan_send_arb.
// Driver pushes per-cycle expectations from a reference model; a negedge monitor pops and compares.
module tb_mygo_chan_send_arb;
    localparam int N = 4;
    localparam int W = 32;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   s_valid = '0;
    logic [N*W-1:0] s_data = '0;
    logic [N-1:0]   s_ready;
    logic [W-1:0]   fifo_in_data;
    logic           fifo_in_valid;
    logic           fifo_in_ready = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
`ifdef MYGO_CHAN_ARB_STATS_EN
    logic [31:0]    xfer_count, stall_count;
`endif

    mygo_chan_send_arb #(.NUM_SENDERS(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fifo_in_data(fifo_in_data), .fifo_in_valid(fifo_in_valid), .fifo_in_ready(fifo_in_ready),
        .grant(grant), .busy(busy)
`ifdef MYGO_CHAN_ARB_STATS_EN
        , .xfer_count(xfer_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] rdy;
        logic         valid;
        logic [W-1:0] data;
        logic         busy;
        logic [31:0]  xfer;
        logic [31:0]  stall;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference: who holds the channel, beats taken this grant, and who has priority next.
    int owner = -1, ptr = 0, taken = 0, xfer_m = 0, stall_m = 0;
    int seq [N];
    bit held [N];
    int acc = -1;

    function automatic logic [W-1:0] mk(int i, int s);
        return {8'(i), 24'(s)};
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit rstv, int vpct, int rpct);
        exp_t e;
        @(posedge clk);
        #1;
        if (acc >= 0) begin
            seq[acc]++;
            held[acc] = 0;
        end
        acc = -1;
        rst = rstv;
        for (int i = 0; i < N; i++) begin
            if (!held[i] && $urandom_range(99) < vpct) held[i] = 1;
            s_valid[i] = held[i];
            s_data[i*W +: W] = held[i] ? mk(i, seq[i]) : W'($urandom);
        end
        fifo_in_ready = ($urandom_range(99) < rpct);
        e = '{grant: '0, rdy: '0, valid: 1'b0, data: '0, busy: 1'b0, xfer: 32'(xfer_m), stall: 32'(stall_m)};
        if (!rstv) begin
            owner = -1; ptr = 0; taken = 0; xfer_m = 0; stall_m = 0;
            e.xfer = 0; e.stall = 0;
        end else if (owner < 0) begin
            for (int k = 0; k < N && owner < 0; k++)
                if (s_valid[(ptr + k) % N]) owner = (ptr + k) % N;
            taken = 0;
        end else begin
            e.grant = N'(1) << owner;
            e.busy  = 1'b1;
            e.valid = s_valid[owner];
            e.data  = s_data[owner*W +: W];
            e.rdy   = fifo_in_ready ? e.grant : '0;
            if (e.valid && fifo_in_ready) begin
                acc = owner;
                taken++;
                xfer_m++;
            end
            if (e.valid && !fifo_in_ready) stall_m++;
            if (!e.valid || taken == MB) begin
                ptr = (owner + 1) % N;
                owner = -1;
            end
        end
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("grant", W'(grant), W'(e.grant));
                chk("busy", W'(busy), W'(e.busy));
                chk("s_ready", W'(s_ready), W'(e.rdy));
                chk("fifo_in_valid", W'(fifo_in_valid), W'(e.valid));
                chk("fifo_in_data", fifo_in_data, e.data);
`ifdef MYGO_CHAN_ARB_STATS_EN
                chk("xfer_count", xfer_count, e.xfer);
                chk("stall_count", stall_count, e.stall);
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            held[i] = 0;
        end
        repeat (3) step(0, 50, 100);
        repeat (400) step(1, 40, 80);
        repeat (60) step(1, 100, 100);
        repeat (20) step(1, 60, 0);
        repeat (200) step(1, 15, 90);
        repeat (2) step(0, 70, 100);
        repeat (300) step(1, 70, 60);
        step(0, 80, 100);
        repeat (200) step(1, 90, 95);
        repeat (4) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mygo_chan_send_arb.md
Name: mygo_chan_send_arb

Overview:
- Round-robin scheduler that shares the write side of one mygo_fifo channel among NUM_SENDERS producer processes. This covers Go channels with several sending goroutines.
- Sits between the per-sender valid/ready/data ports and the FIFO in_data/in_valid/in_ready port.
- Grants one sender at a time for a bounded burst of beats, then rotates priority.

Parameters:
- NUM_SENDERS, 4, number of producers sharing the channel (>=2).
- WIDTH, 32, channel element width in bits; must match the FIFO WIDTH.
- MAX_BURST, 4, maximum beats accepted from one sender per grant (>=1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
- s_valid  input  NUM_SENDERS  per-sender element-available flag.
- s_data  input  NUM_SENDERS*WIDTH  flattened sender data; sender i occupies bits [i*WIDTH +: WIDTH].
- s_ready  output  NUM_SENDERS  per-sender accept; at most one bit set.
- fifo_in_data  output  WIDTH  to FIFO in_data.
- fifo_in_valid  output  1  to FIFO in_valid.
- fifo_in_ready  input  1  from FIFO in_ready.
- grant  output  NUM_SENDERS  registered one-hot current grant; all zeros when idle.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset (rst=0): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - s_ready=0, fifo_in_valid=0, fifo_in_data=0, busy=0.
  - Reset mid-burst aborts the grant at once. No partial handshake is reported.
- State IDLE:
  - Outputs are 0.
  - If any s_valid bit is set, select the first set index searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_SENDERS.
  - Register the winner into grant, clear beat_cnt, and go to GRANT.
  - If no s_valid bit is set, stay in IDLE.
  - Arbitration latency: first s_valid high -> grant one cycle later.
- State GRANT, with g the granted index:
  - fifo_in_valid = s_valid[g].
  - fifo_in_data = s_data slice g.
  - s_ready[g] = fifo_in_ready; all other s_ready bits are 0.
  - Handshake = s_valid[g] & fifo_in_ready. On a handshake, beat_cnt increments.
  - Release the grant when either:
    - a handshake occurs with beat_cnt == MAX_BURST-1 (burst exhausted), or
    - s_valid[g] is low (sender has no more data).
  - On release: grant cleared, rr_ptr = (g+1) mod NUM_SENDERS, go to IDLE next cycle.
  - Otherwise stay in GRANT with the same g. A FIFO stall (fifo_in_ready=0) holds the grant indefinitely with no timeout.
- Bubble: exactly one idle cycle between consecutive grants. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Fairness: a sender continuously requesting waits at most (NUM_SENDERS-1)*(MAX_BURST+1) cycles after any release.
- Non-granted senders' s_valid and s_data are ignored; they must hold their data until accepted.
- beat_cnt width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1 in GRANT.
- No combinational path from s_valid to grant. Combinational paths fifo_in_ready->s_ready and s_valid/s_data->fifo_in_* exist only through the registered grant.

Optional Feature:
- Macro: MYGO_CHAN_ARB_STATS_EN.
- Defined: adds two outputs, xfer_count[31:0] and stall_count[31:0]. Both reset to 0, wrap on overflow, and update the cycle after the event.
  - xfer_count increments on every handshake.
  - stall_count increments on every cycle with fifo_in_valid=1 and fifo_in_ready=0.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Single sender: only s_valid[2]=1 with data 0xA0..0xA5, fifo_in_ready=1, MAX_BURST=4.
  -> grant=4'b0100 at cycle 1; beats A0-A3 accepted; one bubble; A4,A5 accepted; rr_ptr=3 after each release.
- All senders, all s_valid=4'b1111, fifo_in_ready=1.
  -> grant order 0,1,2,3,0; each burst exactly 4 beats; one bubble between bursts; s_ready always one-hot or zero.
- Back-pressure: grant to sender 1, fifo_in_ready=0 for 10 cycles.
  -> grant held; beat_cnt unchanged; no data accepted; stall_count=10 with MYGO_CHAN_ARB_STATS_EN.
- Early drop: sender 0 sends 2 beats, then s_valid[0]=0 while s_valid[3]=1.
  -> release after 2 beats; next grant=4'b1000 two cycles later.
- Reset mid-burst: rst=0 during a burst.
  -> all outputs 0 in the same cycle; after release with s_valid=4'b0110, grant is sender 1 (rr_ptr=0).
